// File: rtl/multi_cycle_mips.sv
// rtl/multi_cycle_mips.sv - multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB) with handshaked fetch and data access
//
// Purpose: executes one MIPS instruction over 2-5 cycles. Instruction fetch waits on
// IR_valid; data accesses drive an SRAM macro with active-low CEN/WEN/OEN and wait
// on mem_ready.
//
// Parameters:
//   DMEM_AW  data address width (A = ALU result [DMEM_AW-1:0])
//   PC_RESET program counter value after reset
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   IR_addr [31:0]      instruction address (the PC)
//   IR [31:0], IR_valid instruction word and its fetch handshake
//   ReadDataMem [31:0]  load data from memory
//   mem_ready           data access completes this cycle
//   CEN, WEN, OEN       active-low chip/write/output enables (registered)
//   A [DMEM_AW-1:0]     data address (registered)
//   Data2Mem [31:0]     store data (registered)
//
// Optional feature, enabled by defining MULTI_CYCLE_MIPS_PERF_EN:
//   perf_instret [31:0] retired instruction count (NOPs included)
//   perf_stall [31:0]   IR_valid=0 FETCH cycles plus mem_ready=0 MEM cycles

module multi_cycle_mips #(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  input  logic               IR_valid,
  input  logic [31:0]        ReadDataMem,
  input  logic               mem_ready,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem
`ifdef MULTI_CYCLE_MIPS_PERF_EN
  ,
  output logic [31:0]        perf_instret,
  output logic [31:0]        perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ir_q;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] imm_q;
  logic [31:0] alu_q;
  logic [31:0] mdr;
  logic [31:0] rf [32];

  assign IR_addr = pc;

  // Instruction fields, always taken from the latched instruction
  logic [5:0] opcode;
  logic [4:0] rs_f;
  logic [4:0] rt_f;
  logic [4:0] rd_f;
  logic [4:0] shamt;
  logic [5:0] funct;

  assign opcode = ir_q[31:26];
  assign rs_f   = ir_q[25:21];
  assign rt_f   = ir_q[20:16];
  assign rd_f   = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];

  logic is_rtype, is_r_alu, is_jr, is_j, is_jal, is_beq, is_bne;
  logic is_addi, is_lw, is_sw;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_r_alu = 1'b0;
    if (is_rtype) begin
      case (funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: is_r_alu = 1'b1;
        default:                                              is_r_alu = 1'b0;
      endcase
    end
    is_jr   = is_rtype && (funct == FN_JR);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_addi = (opcode == OP_ADDI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
  end

  // Anything not recognised retires straight out of DECODE
  logic is_nop;
  assign is_nop = !(is_r_alu || is_jr || is_j || is_jal || is_beq || is_bne ||
                    is_addi || is_lw || is_sw);

  // ALU: immediate operand for addi and address calculation, rt otherwise
  logic [31:0] op_b;
  logic [31:0] alu_res;

  always_comb begin
    op_b    = (is_addi || is_lw || is_sw) ? imm_q : b_reg;
    alu_res = a_reg + op_b;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a_reg - b_reg;
        FN_AND:  alu_res = a_reg & b_reg;
        FN_OR:   alu_res = a_reg | b_reg;
        FN_SLT:  alu_res = {31'b0, ($signed(a_reg) < $signed(b_reg))};
        FN_SLL:  alu_res = b_reg << shamt;
        FN_SRL:  alu_res = b_reg >> shamt;
        default: alu_res = a_reg + b_reg;
      endcase
    end
  end

  logic        br_taken;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  assign br_taken = (a_reg == b_reg) ^ is_bne;
  assign wb_dest  = is_rtype ? rd_f : rt_f;
  assign wb_data  = is_lw ? mdr : alu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= PC_RESET;
      npc      <= '0;
      ir_q     <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      mdr      <= '0;
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (IR_valid) begin
            ir_q  <= IR;
            npc   <= pc + 32'd4;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          a_reg <= rf[rs_f];
          b_reg <= rf[rt_f];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
          if (is_j || is_jal) begin
            pc    <= {npc[31:28], ir_q[25:0], 2'b00};
            state <= S_FETCH;
            if (is_jal) rf[31] <= npc;
          end else if (is_jr) begin
            // a_reg is not loaded yet, so read the register file directly
            pc    <= rf[rs_f];
            state <= S_FETCH;
          end else if (is_nop) begin
            pc    <= npc;
            state <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
          alu_q <= alu_res;
          if (is_beq || is_bne) begin
            pc    <= br_taken ? (npc + (imm_q << 2)) : npc;
            state <= S_FETCH;
          end else if (is_lw || is_sw) begin
            CEN   <= 1'b0;
            OEN   <= !is_lw;
            WEN   <= !is_sw;
            A     <= alu_res[DMEM_AW-1:0];
            if (is_sw) Data2Mem <= b_reg;
            state <= S_MEM;
          end else if (is_r_alu || is_addi) begin
            state <= S_WB;
          end else begin
            pc    <= npc;
            state <= S_FETCH;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            CEN <= 1'b1;
            WEN <= 1'b1;
            OEN <= 1'b1;
            if (is_lw) begin
              mdr   <= ReadDataMem;
              state <= S_WB;
            end else begin
              pc    <= npc;
              state <= S_FETCH;
            end
          end
        end

        S_WB: begin
          if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
          pc    <= npc;
          state <= S_FETCH;
        end

        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef MULTI_CYCLE_MIPS_PERF_EN
  // High on every edge that moves the FSM back into FETCH
  logic retire;
  logic stall;

  always_comb begin
    retire = 1'b0;
    case (state)
      S_DECODE: retire = is_j || is_jal || is_jr || is_nop;
      S_EXEC:   retire = !(is_lw || is_sw || is_r_alu || is_addi);
      S_MEM:    retire = mem_ready && !is_lw;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
    stall = ((state == S_FETCH) && !IR_valid) || ((state == S_MEM) && !mem_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instret <= '0;
      perf_stall   <= '0;
    end else begin
      if (retire) perf_instret <= perf_instret + 32'd1;
      if (stall)  perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
